// File: rtl/arith_share_ctrl.sv
// -----------------------------------------------------------------------------
// arith_share_ctrl
//
// Purpose:
//   Shares one combinational 4-bit arithmetic datapath (add/sub/mult/div)
//   between two requesters. A request is arbitrated, its operands are
//   registered onto the datapath, held for SETTLE_CYCLES, and then the
//   datapath result and flags are captured and handed back with a done pulse.
//
// Parameters:
//   SETTLE_CYCLES  cycles operands are held before capture (1..15, 0 -> 1)
//
// Configuration macro:
//   ARITH_SHARE_FIXED_PRIO_EN  when defined, requester 0 always wins ties
//                              (no round-robin pointer); otherwise round-robin.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req[1:0]                per-requester request, held until its gnt
//   x0,y0,op0 / x1,y1,op1   operands and op (00 add, 01 sub, 10 mult, 11 div)
//   gnt[1:0]                one-hot pulse: request accepted, operands latched
//   done[1:0]               one-hot pulse: result valid for that requester
//   busy                    high from grant until done
//   dp_x, dp_y, dp_op       registered datapath operands / op select
//   dp_ynot                 two's complement of {1'b0,dp_y}, mod 32
//   dp_z                    {dp_y, dp_x} for mult/div
//   dp_result, dp_addsub_ovf, dp_multdiv_ovf   datapath outputs
//   result, addsub_ovf, multdiv_ovf, result_id captured result and owner
// -----------------------------------------------------------------------------
module arith_share_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [3:0] x0,
    input  logic [3:0] y0,
    input  logic [1:0] op0,
    input  logic [3:0] x1,
    input  logic [3:0] y1,
    input  logic [1:0] op1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       busy,
    output logic [3:0] dp_x,
    output logic [3:0] dp_y,
    output logic [4:0] dp_ynot,
    output logic [7:0] dp_z,
    output logic [1:0] dp_op,
    input  logic [7:0] dp_result,
    input  logic       dp_addsub_ovf,
    input  logic [1:0] dp_multdiv_ovf,
    output logic [7:0] result,
    output logic       addsub_ovf,
    output logic [1:0] multdiv_ovf,
    output logic       result_id
);

    // Out-of-range settle values are clamped into the 4-bit counter range.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1)  ? 1 :
                                (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_EFF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       owner_reg, owner_next;
    logic [1:0] gnt_reg, gnt_next;
    logic [1:0] done_reg, done_next;
    logic       busy_reg, busy_next;
    logic [3:0] dp_x_reg, dp_x_next;
    logic [3:0] dp_y_reg, dp_y_next;
    logic [1:0] dp_op_reg, dp_op_next;
    logic [7:0] result_reg, result_next;
    logic       addsub_ovf_reg, addsub_ovf_next;
    logic [1:0] multdiv_ovf_reg, multdiv_ovf_next;
    logic       result_id_reg, result_id_next;
    logic       pick;

`ifndef ARITH_SHARE_FIXED_PRIO_EN
    // Favoured requester for the next tie; flips away from each winner.
    logic       rr_reg, rr_next;
`endif

    // Winner selection. A lone requester always wins; only ties consult
    // the priority scheme.
    always_comb begin
`ifdef ARITH_SHARE_FIXED_PRIO_EN
        pick = req[0] ? 1'b0 : 1'b1;
`else
        pick = (req == 2'b11) ? rr_reg : req[1];
`endif
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        owner_next       = owner_reg;
        gnt_next         = 2'b00;
        done_next        = 2'b00;
        busy_next        = busy_reg;
        dp_x_next        = dp_x_reg;
        dp_y_next        = dp_y_reg;
        dp_op_next       = dp_op_reg;
        result_next      = result_reg;
        addsub_ovf_next  = addsub_ovf_reg;
        multdiv_ovf_next = multdiv_ovf_reg;
        result_id_next   = result_id_reg;
`ifndef ARITH_SHARE_FIXED_PRIO_EN
        rr_next          = rr_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_next     = pick;
                    dp_x_next      = pick ? x1  : x0;
                    dp_y_next      = pick ? y1  : y0;
                    dp_op_next     = pick ? op1 : op0;
                    gnt_next[pick] = 1'b1;
                    busy_next      = 1'b1;
                    cnt_next       = SETTLE_LOAD;
                    state_next     = SETTLE;
`ifndef ARITH_SHARE_FIXED_PRIO_EN
                    rr_next        = ~pick;
`endif
                end
            end
            SETTLE: begin
                // Counter value 1 marks the last settle cycle.
                if (cnt_reg <= 4'd1) begin
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            CAPTURE: begin
                result_next           = dp_result;
                addsub_ovf_next       = dp_addsub_ovf;
                multdiv_ovf_next      = dp_multdiv_ovf;
                result_id_next        = owner_reg;
                done_next[owner_reg]  = 1'b1;
                busy_next             = 1'b0;
                state_next            = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= 4'd0;
            owner_reg       <= 1'b0;
            gnt_reg         <= 2'b00;
            done_reg        <= 2'b00;
            busy_reg        <= 1'b0;
            dp_x_reg        <= 4'd0;
            dp_y_reg        <= 4'd0;
            dp_op_reg       <= 2'd0;
            result_reg      <= 8'd0;
            addsub_ovf_reg  <= 1'b0;
            multdiv_ovf_reg <= 2'b00;
            result_id_reg   <= 1'b0;
`ifndef ARITH_SHARE_FIXED_PRIO_EN
            rr_reg          <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            owner_reg       <= owner_next;
            gnt_reg         <= gnt_next;
            done_reg        <= done_next;
            busy_reg        <= busy_next;
            dp_x_reg        <= dp_x_next;
            dp_y_reg        <= dp_y_next;
            dp_op_reg       <= dp_op_next;
            result_reg      <= result_next;
            addsub_ovf_reg  <= addsub_ovf_next;
            multdiv_ovf_reg <= multdiv_ovf_next;
            result_id_reg   <= result_id_next;
`ifndef ARITH_SHARE_FIXED_PRIO_EN
            rr_reg          <= rr_next;
`endif
        end
    end

    assign gnt         = gnt_reg;
    assign done        = done_reg;
    assign busy        = busy_reg;
    assign dp_x        = dp_x_reg;
    assign dp_y        = dp_y_reg;
    assign dp_op       = dp_op_reg;
    assign dp_ynot     = (~{1'b0, dp_y_reg}) + 5'd1;
    assign dp_z        = {dp_y_reg, dp_x_reg};
    assign result      = result_reg;
    assign addsub_ovf  = addsub_ovf_reg;
    assign multdiv_ovf = multdiv_ovf_reg;
    assign result_id   = result_id_reg;

endmodule

// File: tb/tb_arith_share_ctrl.sv
module tb_arith_share_ctrl;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [3:0] x0 = 4'd0, y0 = 4'd0, x1 = 4'd0, y1 = 4'd0;
    logic [1:0] op0 = 2'd0, op1 = 2'd0;
    logic [1:0] gnt, done, dp_op, multdiv_ovf;
    logic       busy, addsub_ovf, result_id;
    logic [3:0] dp_x, dp_y;
    logic [4:0] dp_ynot;
    logic [7:0] dp_z, result;
    logic [7:0] dp_result;
    logic       dp_addsub_ovf;
    logic [1:0] dp_multdiv_ovf;
    logic [4:0] s5;
    logic [7:0] p8;

    arith_share_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .x0(x0), .y0(y0), .op0(op0), .x1(x1), .y1(y1), .op1(op1),
        .gnt(gnt), .done(done), .busy(busy),
        .dp_x(dp_x), .dp_y(dp_y), .dp_ynot(dp_ynot), .dp_z(dp_z), .dp_op(dp_op),
        .dp_result(dp_result), .dp_addsub_ovf(dp_addsub_ovf),
        .dp_multdiv_ovf(dp_multdiv_ovf),
        .result(result), .addsub_ovf(addsub_ovf), .multdiv_ovf(multdiv_ovf),
        .result_id(result_id)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: sub uses dp_ynot, mult/div use dp_z.
    always_comb begin
        dp_result      = 8'd0;
        dp_addsub_ovf  = 1'b0;
        dp_multdiv_ovf = 2'b00;
        s5             = 5'd0;
        p8             = 8'd0;
        case (dp_op)
            2'd0: begin
                s5 = {1'b0, dp_x} + {1'b0, dp_y};
                dp_result = {3'b000, s5}; dp_addsub_ovf = s5[4];
            end
            2'd1: begin
                s5 = {1'b0, dp_x} + dp_ynot;
                dp_result = {3'b000, s5}; dp_addsub_ovf = s5[4];
            end
            2'd2: begin
                p8 = {4'd0, dp_z[3:0]} * {4'd0, dp_z[7:4]};
                dp_result = p8; dp_multdiv_ovf = {(p8 > 8'd15), 1'b0};
            end
            default: begin
                if (dp_z[7:4] == 4'd0) begin
                    dp_result = 8'hFF; dp_multdiv_ovf = 2'b01;
                end else begin
                    dp_result = {dp_z[3:0] % dp_z[7:4], dp_z[3:0] / dp_z[7:4]};
                    dp_multdiv_ovf = {((dp_z[3:0] % dp_z[7:4]) != 4'd0), 1'b0};
                end
            end
        endcase
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [7:0] r;
        logic       as;
        logic [1:0] md;
    } calc_t;

    // Expected arithmetic straight from operand values.
    function automatic calc_t ref_calc(input int x, input int y, input int op);
        calc_t c;
        int v;
        c = '0;
        case (op)
            0: begin v = x + y; c.r = 8'(v); c.as = (v >= 16); end
            1: begin v = (x - y + 32) % 32; c.r = 8'(v); c.as = (v >= 16); end
            2: begin v = x * y; c.r = 8'(v); c.md = {(v > 15), 1'b0}; end
            default: begin
                if (y == 0) begin
                    c.r = 8'hFF; c.md = 2'b01;
                end else begin
                    c.r = 8'((x % y) * 16 + x / y);
                    c.md = {((x % y) != 0), 1'b0};
                end
            end
        endcase
        return c;
    endfunction

    typedef struct {
        logic [1:0] req;
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] op;
        logic [7:0] r;
        logic       as;
        logic [1:0] md;
    } vec_t;

    vec_t tbl[8];

    // Random-phase model state
    int         next_sample, last_g, done_edge, w, pend_id;
    logic       fav;
    calc_t      pend, cur;
    logic [1:0] exp_gnt, exp_done;
    logic [3:0] exp_x, exp_y;
    logic [1:0] exp_op;
    logic       exp_busy, exp_id;
    int         found, low_cnt, prev_g;
    logic [1:0] cont_exp;

    initial begin
        tbl[0] = '{2'b01, 4'd3,  4'd4, 2'd0, 8'h07, 1'b0, 2'b00};
        tbl[1] = '{2'b10, 4'd2,  4'd5, 2'd1, 8'h1D, 1'b1, 2'b00};
        tbl[2] = '{2'b01, 4'd15, 4'd15,2'd0, 8'h1E, 1'b1, 2'b00};
        tbl[3] = '{2'b10, 4'd7,  4'd3, 2'd2, 8'h15, 1'b0, 2'b10};
        tbl[4] = '{2'b01, 4'd13, 4'd4, 2'd3, 8'h13, 1'b0, 2'b10};
        tbl[5] = '{2'b10, 4'd9,  4'd0, 2'd3, 8'hFF, 1'b0, 2'b01};
        tbl[6] = '{2'b01, 4'd5,  4'd5, 2'd1, 8'h00, 1'b0, 2'b00};
        tbl[7] = '{2'b01, 4'd4,  4'd2, 2'd2, 8'h08, 1'b0, 2'b00};

        // Reset state
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 0);
        chk("rst_dp_z", dp_z, 0);
        do_reset();

        // Table: one transaction per record, back-to-back issue
        for (int i = 0; i < 8; i++) begin
            x0 = 4'($urandom); y0 = 4'($urandom); op0 = 2'($urandom);
            x1 = 4'($urandom); y1 = 4'($urandom); op1 = 2'($urandom);
            if (tbl[i].req[0]) begin x0 = tbl[i].x; y0 = tbl[i].y; op0 = tbl[i].op; end
            else begin x1 = tbl[i].x; y1 = tbl[i].y; op1 = tbl[i].op; end
            req = tbl[i].req;
            tick();
            chk("tbl_gnt", gnt, tbl[i].req);
            chk("tbl_busy", busy, 1);
            chk("tbl_dp_op", dp_op, tbl[i].op);
            chk("tbl_dp_z", dp_z, {tbl[i].y, tbl[i].x});
            chk("tbl_dp_ynot", dp_ynot, (32 - int'(tbl[i].y)) % 32);
            req = 2'b00;
            x0 = 4'($urandom); y0 = 4'($urandom); x1 = 4'($urandom); y1 = 4'($urandom);
            for (int k = 0; k < S; k++) begin
                tick();
                chk("tbl_no_done", done, 0);
            end
            tick();
            chk("tbl_done", done, tbl[i].req);
            chk("tbl_result", result, tbl[i].r);
            chk("tbl_as", addsub_ovf, tbl[i].as);
            chk("tbl_md", multdiv_ovf, tbl[i].md);
            chk("tbl_id", result_id, tbl[i].req[1]);
            chk("tbl_busy_low", busy, 0);
            $display("tbl %0d: req=%b x=%0d y=%0d op=%0d result=0x%02h", i, tbl[i].req,
                     tbl[i].x, tbl[i].y, tbl[i].op, result);
        end

        // Reset in the middle of SETTLE
        req = 2'b01; x0 = 4'd6; y0 = 4'd7; op0 = 2'd0;
        tick();
        req = 2'b00;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_dp_x", dp_x, 0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < S + 3; k++) begin
            tick();
            chk("mid_rst_no_done", done, 0);
        end
        $display("mid-settle reset: outputs cleared, no done");

        // Contention from reset
        do_reset();
        req = 2'b11;
        prev_g = 0;
        for (int k = 0; k < 4; k++) begin
            found = 0; low_cnt = 0;
            for (int t = 0; t < 12 && found == 0; t++) begin
                tick();
                if (gnt != 2'b00) found = 1;
                else if (busy == 1'b0) low_cnt++;
            end
`ifdef ARITH_SHARE_FIXED_PRIO_EN
            cont_exp = 2'b01;
`else
            cont_exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            chk("cont_found", found, 1);
            chk("cont_gnt", gnt, cont_exp);
            if (k > 0) begin
                chk("cont_period", cyc - prev_g, S + 2);
                chk("cont_busy_low", low_cnt, 1);
            end
            prev_g = cyc;
            $display("contention grant %0d: gnt=%b", k, gnt);
        end
        req = 2'b00;
        repeat (S + 2) tick();
        req = 2'b10;
        tick();
        chk("lone_req1_gnt", gnt, 2'b10);
        req = 2'b00;
        repeat (S + 2) tick();

        // Randomized run against the transaction-level model
        do_reset();
        next_sample = 0; last_g = -100; done_edge = -1; fav = 1'b0;
        pend = '0; pend_id = 0; exp_x = 0; exp_y = 0; exp_op = 0; exp_id = 0;
        cur = '0;
        for (int e = 0; e < 400; e++) begin
            req = 2'($urandom_range(0, 3));
            x0 = 4'($urandom); y0 = 4'($urandom); op0 = 2'($urandom);
            x1 = 4'($urandom); y1 = 4'($urandom); op1 = 2'($urandom);
            exp_gnt = 2'b00; exp_done = 2'b00;
            if (e >= next_sample && req != 2'b00) begin
`ifdef ARITH_SHARE_FIXED_PRIO_EN
                w = (req[0]) ? 0 : 1;
`else
                w = (req == 2'b11) ? int'(fav) : int'(req[1]);
                fav = (w == 0);
`endif
                exp_gnt = (w == 0) ? 2'b01 : 2'b10;
                exp_x = w ? x1 : x0; exp_y = w ? y1 : y0; exp_op = w ? op1 : op0;
                pend = ref_calc(int'(exp_x), int'(exp_y), int'(exp_op));
                pend_id = w;
                last_g = e; next_sample = e + S + 2; done_edge = e + S + 1;
            end
            if (e == done_edge) begin
                exp_done = (pend_id == 0) ? 2'b01 : 2'b10;
                cur = pend;
                exp_id = (pend_id == 1);
            end
            exp_busy = (e >= last_g) && (e <= last_g + S);
            tick();
            chk("rnd_gnt", gnt, exp_gnt);
            chk("rnd_done", done, exp_done);
            chk("rnd_busy", busy, exp_busy);
            chk("rnd_dp_x", dp_x, exp_x);
            chk("rnd_dp_y", dp_y, exp_y);
            chk("rnd_dp_op", dp_op, exp_op);
            chk("rnd_result", result, cur.r);
            chk("rnd_as", addsub_ovf, cur.as);
            chk("rnd_md", multdiv_ovf, cur.md);
            chk("rnd_id", result_id, exp_id);
            if (exp_done != 2'b00)
                $display("rnd edge %0d: done=%b result=0x%02h id=%0d", e, done, result, result_id);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
